// File: rtl/uart_receiver.sv
// UART receive stage: over-samples rxd, checks start/stop bits and
// writes each good word to a downstream FIFO, flagging framing errors and overruns.
module uart_receiver #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int WORD_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    output logic [WORD_WIDTH-1:0] dout,
    output logic                  we,
    input  logic                  full,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int CPB = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int IW  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    // Full-bit reload counts CPB cycles down to zero.
    localparam logic [CW-1:0] FULL_LOAD = CW'(CPB - 1);
    // Half-bit reload is one cycle short so the start-bit sample lands
    // near the bit centre despite the two synchronizer stages in front.
    localparam logic [CW-1:0] HALF_LOAD = CW'(CPB / 2 - 2);
    localparam logic [IW-1:0] LAST_IDX  = IW'(WORD_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state_q, state_d;

    logic                  sync1_q;
    logic                  rx_s_q;
    logic                  rx_prev_q;
    logic [CW-1:0]         timer_q, timer_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [WORD_WIDTH-1:0] dout_q, dout_d;
    logic                  we_q, we_d;
    logic                  fe_q, fe_d;
    logic                  ov_q, ov_d;

    logic tick;
    logic fall;

    assign tick = (timer_q == '0);
    assign fall = rx_prev_q & ~rx_s_q;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rxd;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, baud timer, bit index, shift register and output pulses.
    always_comb begin
        state_d = state_q;
        timer_d = tick ? timer_q : timer_q - 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        we_d    = 1'b0;
        fe_d    = 1'b0;
        ov_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                    timer_d = HALF_LOAD;
                end
            end

            S_START: begin
                if (tick) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        timer_d = FULL_LOAD;
                        idx_d   = '0;
                    end
                end
            end

            S_DATA: begin
                if (tick) begin
                    shift_d[idx_q] = rx_s_q;
                    timer_d        = FULL_LOAD;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            S_STOP: begin
                if (tick) begin
                    if (!rx_s_q) begin
                        fe_d    = 1'b1;
                        state_d = S_BREAK;
                    end else if (full) begin
                        ov_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        dout_d  = shift_q;
                        we_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath registers and registered output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            we_q    <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            we_q    <= we_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    assign dout      = dout_q;
    assign we        = we_q;
    assign frame_err = fe_q;
    assign overrun   = ov_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receive stage; the counterpart of the existing transmitter on the other end of the line.
- Frame format: 8N1 by default, LSB first, idle-high line.
- Over-samples the asynchronous rx pin with the system clock, validates start and stop bits, and pushes each good word into a downstream byte FIFO via a write-strobe/full handshake (mirror of the transmitter's empty/re interface).
- Reports framing errors and overruns as single-cycle pulses for status/LED logic.

Parameters:
CLOCK_FREQUENCY, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bits/s; CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE (integer division), must be >= 4
WORD_WIDTH, 8, data bits per frame

Ports:
clk  input  1  system clock; the block's only clock
rst  input  1  synchronous, active-high reset
rxd  input  1  asynchronous serial input, idle high
dout  output  WORD_WIDTH  received word, LSB = first data bit on the line
we  output  1  one-cycle write strobe to downstream FIFO; dout valid in the same cycle
full  input  1  downstream FIFO full; sampled only in the cycle a word completes
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: good word dropped because full=1
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at posedge clk):
  - State goes to IDLE; all counters clear.
  - dout=0, we=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops are set to 1 (idle level).
  - Reset mid-frame abandons the frame with no pulses.
- Input conditioning:
  - rxd passes through a 2-flop synchronizer.
  - All logic uses the synchronized value rx_s.
  - A falling edge is rx_s=0 with the previous rx_s=1.
- Baud timer: a counter of width $clog2(CYCLES_PER_BIT) loads on each state entry. A sample tick occurs when it reaches its terminal count.
- States:
  - IDLE: on a falling edge, go to START with the timer set to CYCLES_PER_BIT/2 (half bit).
  - START: at the half-bit tick, sample rx_s.
    - If 1 (glitch): return to IDLE, no pulses.
    - If 0: go to DATA, bit index 0, timer set to a full bit.
  - DATA: at each full-bit tick, shift rx_s into bit [index] (LSB first).
    - After bit WORD_WIDTH-1, go to STOP with a full-bit timer.
  - STOP: at the full-bit tick, sample rx_s.
    - rx_s=1, full=0: dout <= shift register, we=1 for exactly one cycle, go to IDLE.
    - rx_s=1, full=1: overrun=1 for one cycle; dout is not updated and we stays 0; go to IDLE.
    - rx_s=0: frame_err=1 for one cycle, no write, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. This prevents a held-low line (break) from being decoded as repeated 0x00 frames.
- dout holds its last written value between strobes.
- Latency: we rises 2 (synchronizer) + CYCLES_PER_BIT/2 + (WORD_WIDTH+1)*CYCLES_PER_BIT cycles after the rxd falling edge, ±1 cycle.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start bit immediately following the stop bit is caught with no lost frame.
- Simultaneous events: frame_err and overrun are mutually exclusive; a framing error takes priority and full is ignored.
- Baud tolerance: up to ±4% rate mismatch must receive correctly (centre sampling).

Test Plan:
(All with CLOCK_FREQUENCY=1_000_000, BAUD_RATE=100_000, i.e. 10 cycles/bit, full=0 unless stated.)
1. Bench UART model sends 0x55 then 0xA3 back-to-back with no idle gap -> exactly two we pulses, with dout=0x55 then 0xA3; frame_err=overrun=0 throughout.
2. rxd low for 3 cycles then high -> START rejects the glitch; no we, no frame_err; busy returns to 0 within 10 cycles.
3. Frame 0x0F with stop bit driven 0, then line held low 50 cycles, then high -> one frame_err pulse, no we; no further frames decoded until line high; next frame 0x3C received correctly.
4. full=1 held during frame 0x81 -> one overrun pulse, we=0, dout keeps previous value; after releasing full, frame 0x7E -> we with dout=0x7E.
5. rst asserted for 1 cycle at mid-data of frame 0xC6 -> all outputs 0 next cycle, no we for that frame; next complete frame 0x12 received with dout=0x12.
6. Sender bit period 10.4 cycles (+4%) and 9.6 cycles (-4%), frames 0x00, 0xFF, 0x5A -> all received correctly, no errors.
